// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer between pipeline stages. The output register feeds the
// downstream stage; the skid register catches the one beat that can arrive while
// downstream stalls. in_ready comes from a register only, so out_ready never
// reaches upstream combinationally. Control and sideband fields read as zero
// whenever no beat is held, so an empty or flushed stage has no side effects.
module pipe_stage_buffer #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned PC_W   = 48,
  parameter int unsigned SIDE_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data_a,
  input  logic [DATA_W-1:0] in_data_b,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [SIDE_W-1:0] in_side,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PC_W-1:0]   out_pc,
  output logic [SIDE_W-1:0] out_side,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Payload packed as {ctrl, data_a, data_b, addr, pc, side}, side in the LSBs.
  localparam int unsigned OffPc   = SIDE_W;
  localparam int unsigned OffAddr = OffPc + PC_W;
  localparam int unsigned OffB    = OffAddr + ADDR_W;
  localparam int unsigned OffA    = OffB + DATA_W;
  localparam int unsigned OffCtrl = OffA + DATA_W;
  localparam int unsigned PayW    = OffCtrl + CTRL_W;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic [PayW-1:0]   out_q, out_d;
  logic [PayW-1:0]   skid_q, skid_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PayW-1:0]   in_pay;
  logic              accept, consume, stall;

  assign in_pay  = {in_ctrl, in_data_a, in_data_b, in_addr, in_pc, in_side};
  assign accept  = in_valid & ready_q;
  assign consume = out_valid & out_ready;
  assign stall   = out_valid & ~out_ready;

  // Next-state, payload steering and stall counter update.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          out_d   = in_pay;
        end
      end
      StOne: begin
        if (accept && consume) begin
          out_d = in_pay;
        end else if (accept) begin
          state_d = StFull;
          skid_d  = in_pay;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (consume) begin
          state_d = StOne;
          out_d   = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over everything; data fields keep their last loaded value.
    if (flush) begin
      state_d = StEmpty;
      out_d   = out_q;
      skid_d  = skid_q;
    end
    ready_d = (state_d != StFull);
    cnt_d   = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and payload registers; ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = (state_q != StEmpty);
  assign stall_cnt  = cnt_q;
  assign out_ctrl   = out_valid ? out_q[OffCtrl +: CTRL_W] : '0;
  assign out_side   = out_valid ? out_q[0 +: SIDE_W] : '0;
  assign out_data_a = out_q[OffA +: DATA_W];
  assign out_data_b = out_q[OffB +: DATA_W];
  assign out_addr   = out_q[OffAddr +: ADDR_W];
  assign out_pc     = out_q[OffPc +: PC_W];

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 SHALL provide parameter CTRL_W, default 10, width of control field; zeroed on flush and while empty.
REQ-002 SHALL provide parameter DATA_W, default 16, width of each of the two data operands (ALU result, store data).
REQ-003 SHALL provide parameter ADDR_W, default 3, width of write-back register address.
REQ-004 SHALL provide parameter PC_W, default 48, width of PC/return-address field.
REQ-005 SHALL provide parameter SIDE_W, default 3, width of sideband flags (interrupt, ret, rti).
REQ-006 SHALL provide parameter CNT_W, default 8, width of stall counter.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 in_valid  input  1  upstream beat present.
REQ-010 in_ready  output  1  buffer can accept a beat this cycle.
REQ-011 in_ctrl / in_data_a / in_data_b / in_addr / in_pc / in_side  input  CTRL_W / DATA_W / DATA_W / ADDR_W / PC_W / SIDE_W  upstream payload.
REQ-012 flush  input  1  discard all held beats and the beat presented this cycle.
REQ-013 out_valid  output  1  downstream beat present.
REQ-014 out_ready  input  1  downstream consumes beat this cycle.
REQ-015 out_ctrl / out_data_a / out_data_b / out_addr / out_pc / out_side  output  same widths as inputs  downstream payload.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Accept event SHALL be in_valid&in_ready; consume event SHALL be out_valid&out_ready, both sampled at the rising edge.
REQ-018 Storage SHALL be a 2-entry skid buffer (output register + skid register) with states EMPTY, ONE, FULL.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, driven from registered state only (no combinational path from out_ready).
REQ-020 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-021 EMPTY: accept -> ONE, output register loads input; otherwise stay.
REQ-022 ONE: accept&consume -> ONE, output register loads input; accept only -> FULL, skid loads input; consume only -> EMPTY; neither -> ONE, payload held.
REQ-023 FULL: consume -> ONE, output register loads skid; otherwise stay, payload held.
REQ-024 Beats SHALL leave in acceptance order; no beat duplicated or lost except by flush.
REQ-025 Latency from accept in EMPTY to out_valid=1 SHALL be exactly one cycle.
REQ-026 flush=1 SHALL force next state EMPTY regardless of accept/consume that cycle; the accepted beat (if any) is discarded.
REQ-027 out_side SHALL be zero whenever out_valid=0; out_ctrl SHALL likewise be zero, so a flushed stage issues no write or memory action.
REQ-028 out_data_a, out_data_b, out_addr, out_pc SHALL hold last loaded values while EMPTY (don't-care to downstream).
REQ-029 stall_cnt SHALL increment by 1 per stall cycle, saturate at 2^CNT_W-1, and never wrap; flush SHALL NOT clear it.
REQ-030 All widths SHALL be fully parametric; no field truncated or sign-extended.

Reset
REQ-031 reset_n=0 SHALL immediately (without clock) force state EMPTY, out_valid=0, all out_* payload fields=0, stall_cnt=0.
REQ-032 During reset in_ready SHALL be 0; it SHALL become 1 on the first rising edge after reset_n deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard both held beats; no beat from before reset appears afterward.

Verification
REQ-034 Pass-through: out_ready=1, beats pc=0x10,0x11,0x12 on consecutive cycles -> out_pc 0x10,0x11,0x12 one cycle later each, in_ready stays 1.
REQ-035 Backpressure: out_ready=0, send A(data_a=0x1111), B(0x2222), C -> A,B held, in_ready=0 after B, C not accepted; stall_cnt counts; release out_ready -> A then B, then C accepted.
REQ-036 Flush: FULL with A,B, assert flush with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, out_side=0; A,B,C never appear.
REQ-037 Simultaneous accept+consume in ONE -> state stays ONE, output updates to new beat, no bubble.
REQ-038 Async reset: assert reset_n=0 mid-cycle while FULL -> outputs zero before next edge; after release in_ready=1, out_valid=0, stall_cnt=0.
REQ-039 Saturation: CNT_W=3, stall 10 cycles -> stall_cnt=7 and remains 7.
